mips_lsu: RTL and testbench
===========================

MIPS_LSU -- requirements
Module: mips_lsu

Interface
REQ-001 Parameter DATA_W, default 32, meaning memory/register data width (legal values 32 or 64); NB = DATA_W/8 byte lanes.
REQ-002 Parameter BIG_ENDIAN, default 1, meaning that, when 1, byte address offset 0 maps to lane NB-1 (bits DATA_W-1:DATA_W-8); when 0, offset 0 maps to lane 0.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 en  in  1  global enable; when low, all state and outputs hold.
REQ-006 req_valid  in  1  EX-stage memory operation present.
REQ-007 req_ready  out  1  unit accepts an operation this cycle; equals (state==IDLE).
REQ-008 req_store  in  1  1 = store/SC, 0 = load/LL.
REQ-009 req_size  in  2  0 byte, 1 halfword, 2 word, 3 doubleword (doubleword legal only when DATA_W=64).
REQ-010 req_signed  in  1  sign-extend load result.
REQ-011 req_atomic  in  1  LL when load, SC when store.
REQ-012 req_addr  in  32  byte address.
REQ-013 req_wdata  in  DATA_W  store data, right-justified.
REQ-014 mem_req_valid  out  1  memory request pending.
REQ-015 mem_req_ready  in  1  memory accepts the request this cycle.
REQ-016 mem_addr  out  32  request address, with the low log2(NB) bits forced to 0.
REQ-017 mem_write_en  out  NB  per-lane write strobe; all 0 for reads.
REQ-018 mem_write_data  out  DATA_W  lane-aligned store data.
REQ-019 mem_rsp_valid  in  1  read data valid.
REQ-020 mem_read_data  in  DATA_W  read data.
REQ-021 snoop_inv  in  1  external write hit on the reservation; clears the reservation.
REQ-022 rsp_valid  out  1  one-cycle completion pulse.
REQ-023 rsp_data  out  DATA_W  load result, or SC status (1 = success, 0 = fail).
REQ-024 rsp_err  out  1  misalignment or illegal size flag, valid with rsp_valid.
REQ-025 busy  out  1  pipeline stall request; equals req_valid & ~req_ready, OR state in {REQ, WAIT}.

Function
REQ-026 The FSM SHALL have exactly four states: IDLE, REQ, WAIT, DONE; all transitions occur only when en=1.
REQ-027 In IDLE, req_valid=1 SHALL capture all req_* fields into internal registers.
- If the access is misaligned or the size is illegal, next state = DONE with rsp_err=1.
- If it is an SC and the reservation is invalid or its address mismatches, next state = DONE with rsp_data=0 and no memory access.
- Otherwise next state = REQ.
REQ-028 Alignment rule: halfword requires addr[0]=0; word requires addr[1:0]=0; doubleword requires addr[2:0]=0.
REQ-029 In REQ, mem_req_valid SHALL be 1, with address, strobes and data held stable until mem_req_ready=1.
- On acceptance, a store SHALL go to DONE.
- On acceptance, a load SHALL go to WAIT.
REQ-030 In WAIT, the unit SHALL wait for mem_rsp_valid=1, then capture the extracted and extended data and go to DONE; there is no timeout.
REQ-031 In DONE, rsp_valid SHALL be 1 for exactly one en-cycle, then the state returns to IDLE.
- Minimum latency: store = 3 cycles from request acceptance to rsp_valid; load = 4 cycles with zero-wait memory.
REQ-032 Store lanes:
- The byte or halfword is replicated across all lanes.
- mem_write_en sets only the addressed lanes, with lane selection per BIG_ENDIAN.
- A full-width store sets all NB strobes.
REQ-033 Load extraction:
- Select the addressed lanes per BIG_ENDIAN and right-justify the result.
- Zero- or sign-extend to DATA_W per req_signed.
- A word load on DATA_W=64 extends from bit 31.
REQ-034 Reservation (valid bit plus word-granular address):
- Set on LL completion, with the address set to the LL address.
- Cleared by any completed store or SC from this unit, by snoop_inv, or by rst.
- snoop_inv in the same cycle as an LL completion: the clear SHALL win.
REQ-035 A successful SC SHALL perform its write and return rsp_data=1.
REQ-036 rsp_data and rsp_err SHALL hold their last values outside DONE.

Reset
REQ-037 While rst=1, regardless of en, the unit SHALL force:
- state = IDLE
- reservation invalid
- mem_req_valid=0, mem_write_en=0, rsp_valid=0, rsp_err=0
- rsp_data=0, mem_addr=0, mem_write_data=0
REQ-038 rst asserted mid-operation (REQ or WAIT) SHALL abandon the operation without producing rsp_valid, and SHALL ignore any later mem_rsp_valid while in IDLE.

Verification
REQ-039 Directed scenarios a bench SHALL cover (DATA_W=32, BIG_ENDIAN=1 unless stated):
- sb to addr 0x101 with wdata=0xAB -> mem_write_en=4'b0100, mem_write_data=0xABABABAB, mem_addr=0x100.
- lh signed from 0x102 with mem_read_data=0x1234F00D -> rsp_data=0xFFFFF00D; with BIG_ENDIAN=0 -> rsp_data=0x00001234.
- LL to 0x200, then SC to 0x200 -> SC writes and rsp_data=1; repeat with snoop_inv pulsed between LL and SC -> no mem_req_valid, rsp_data=0.
- lw from 0x203 -> rsp_err=1, no mem_req_valid, busy deasserts after DONE.
- mem_req_ready held low for 5 cycles -> mem_req_valid and mem_addr stable throughout, busy=1; then rst mid-WAIT -> state IDLE, no rsp_valid.
- DATA_W=64: ld from 0x8 with req_size=3 -> all 8 strobes 0 on read and rsp_data = mem_read_data; sw to 0x4 -> mem_write_en=8'h0F (big-endian).

Source files
------------

// File: rtl/mips_lsu.sv
// mips_lsu: single-outstanding load/store unit for a MIPS-style pipeline.
// It accepts one memory operation per visit to IDLE, drives an aligned
// memory request with per-lane strobes, extracts and extends load data, and
// tracks one LL/SC reservation (valid bit plus word address).
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge with en=1
// when both valid and ready are high. The producer must keep valid and its
// payload stable until that edge. mem_rsp_valid has no ready; it is consumed
// only in WAIT and is ignored in every other state.
module mips_lsu #(
    parameter int DATA_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic              req_atomic,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [31:0]       mem_addr,
    output logic [DATA_W/8-1:0] mem_write_en,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              snoop_inv,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // FSM state and captured request fields
    state_t            state_q;
    logic              store_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic              atomic_q;
    logic [31:0]       addr_q;

    // Registered outputs
    logic              mem_req_valid_q;
    logic [31:0]       mem_addr_q;
    logic [NB-1:0]     mem_write_en_q;
    logic [DATA_W-1:0] mem_write_data_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;

    // Reservation: valid bit plus word-granular address
    logic              res_valid_q;
    logic [29:0]       res_addr_q;

    // Combinational decode of the incoming request
    logic              bad_d;
    logic              sc_ok_d;
    logic [NB-1:0]     strb_d;
    logic [DATA_W-1:0] wdata_d;
    logic [31:0]       mem_addr_d;

    // Combinational extraction of the returning load data
    logic [3:0]        ld_bytes;
    logic [3:0]        ld_off;
    logic [3:0]        ld_shift;
    logic [DATA_W-1:0] ld_shifted;
    logic [DATA_W-1:0] ld_keep;
    logic              ld_sign;
    logic [DATA_W-1:0] load_d;

    assign req_ready      = (state_q == IDLE);
    assign busy           = (req_valid & ~req_ready) | (state_q == REQ) | (state_q == WAIT);
    assign dbg_state      = state_q;
    assign mem_req_valid  = mem_req_valid_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_en   = mem_write_en_q;
    assign mem_write_data = mem_write_data_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_err        = rsp_err_q;

    // Decode the request: alignment/size legality, SC outcome, strobes and lane data
    always_comb begin
        int  off_i;
        int  nbytes_i;
        logic lane_hit;

        off_i    = int'(req_addr[LB-1:0]);
        nbytes_i = 1 << req_size;
        lane_hit = 1'b0;

        case (req_size)
            2'd0:    bad_d = 1'b0;
            2'd1:    bad_d = req_addr[0];
            2'd2:    bad_d = |req_addr[1:0];
            default: bad_d = (DATA_W != 64) || (|req_addr[2:0]);
        endcase

        // A snoop arriving with the SC itself already kills the reservation.
        sc_ok_d = res_valid_q && (res_addr_q == req_addr[31:2]) && !snoop_inv;

        // Strobes are built in byte-offset order, then mapped onto lanes.
        strb_d = '0;
        for (int k = 0; k < NB; k++) begin
            lane_hit = (k >= off_i) && (k < off_i + nbytes_i);
            if (BIG_ENDIAN) begin
                strb_d[NB-1-k] = lane_hit;
            end else begin
                strb_d[k] = lane_hit;
            end
        end

        // Narrow data is replicated so every candidate lane carries it; the
        // strobes decide which lanes are written. Replication preserves the
        // byte order inside a halfword/word for both endiannesses.
        case (req_size)
            2'd0:    wdata_d = {NB{req_wdata[7:0]}};
            2'd1:    wdata_d = {(NB/2){req_wdata[15:0]}};
            2'd2:    wdata_d = {(NB/4){req_wdata[31:0]}};
            default: wdata_d = req_wdata;
        endcase

        mem_addr_d = {req_addr[31:LB], {LB{1'b0}}};
    end

    // Extract the addressed bytes from read data, right-justify, then extend
    always_comb begin
        ld_bytes = 4'd1 << size_q;
        ld_off   = 4'(addr_q[LB-1:0]);
        // Big-endian: the access occupies lanes NB-off-n .. NB-1-off.
        ld_shift = BIG_ENDIAN ? (4'(NB) - ld_off - ld_bytes) : ld_off;
        ld_shifted = mem_read_data >> {ld_shift, 3'b000};

        case (size_q)
            2'd0: begin
                ld_keep = DATA_W'(8'hFF);
                ld_sign = ld_shifted[7];
            end
            2'd1: begin
                ld_keep = DATA_W'(16'hFFFF);
                ld_sign = ld_shifted[15];
            end
            2'd2: begin
                ld_keep = DATA_W'(32'hFFFF_FFFF);
                ld_sign = ld_shifted[31];
            end
            default: begin
                ld_keep = '1;
                ld_sign = ld_shifted[DATA_W-1];
            end
        endcase

        load_d = (ld_shifted & ld_keep) | ((signed_q && ld_sign) ? ~ld_keep : '0);
    end

    // Operation FSM with registered memory-side and response-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            store_q          <= 1'b0;
            size_q           <= 2'd0;
            signed_q         <= 1'b0;
            atomic_q         <= 1'b0;
            addr_q           <= '0;
            mem_req_valid_q  <= 1'b0;
            mem_addr_q       <= '0;
            mem_write_en_q   <= '0;
            mem_write_data_q <= '0;
            rsp_valid_q      <= 1'b0;
            rsp_data_q       <= '0;
            rsp_err_q        <= 1'b0;
            res_valid_q      <= 1'b0;
            res_addr_q       <= '0;
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        store_q  <= req_store;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        atomic_q <= req_atomic;
                        addr_q   <= req_addr;
                        if (bad_d) begin
                            state_q     <= DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                            if (req_store) begin
                                res_valid_q <= 1'b0;
                            end
                        end else if (req_store && req_atomic && !sc_ok_d) begin
                            // Failed SC completes without touching memory.
                            state_q     <= DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_data_q  <= '0;
                            res_valid_q <= 1'b0;
                        end else begin
                            state_q         <= REQ;
                            mem_req_valid_q <= 1'b1;
                            mem_addr_q      <= mem_addr_d;
                            mem_write_en_q  <= req_store ? strb_d : '0;
                            if (req_store) begin
                                mem_write_data_q <= wdata_d;
                            end
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        mem_write_en_q  <= '0;
                        if (store_q) begin
                            state_q     <= DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_data_q  <= atomic_q ? DATA_W'(1) : '0;
                            res_valid_q <= 1'b0;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        state_q     <= DONE;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= load_d;
                        if (atomic_q) begin
                            res_valid_q <= 1'b1;
                            res_addr_q  <= addr_q[31:2];
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
            // Placed last so an invalidate beats a same-cycle LL completion.
            if (snoop_inv) begin
                res_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mips_lsu.sv
// Testbench for mips_lsu: three instances (32-bit big-endian, 32-bit
// little-endian, 64-bit big-endian) share one stimulus stream; each check
// reads the instance it is about.
module tb_mips_lsu;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam int OP_CYCLES = 7;

    // ---------------- clock / reset / shared stimulus ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        req_valid;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        req_atomic;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [63:0] mem_rdata;
    logic        snoop_inv;

    always #5 clk = ~clk;

    // ---------------- DUT outputs ----------------
    logic        a_rdy, a_mrv, a_wr_dummy, a_rv, a_re, a_busy;
    logic [31:0] a_maddr, a_wd, a_rd;
    logic [3:0]  a_wen;
    logic [1:0]  a_st;
    logic        b_rdy, b_mrv, b_rv, b_re, b_busy;
    logic [31:0] b_maddr, b_wd, b_rd;
    logic [3:0]  b_wen;
    logic [1:0]  b_st;
    logic        c_rdy, c_mrv, c_rv, c_re, c_busy;
    logic [31:0] c_maddr;
    logic [63:0] c_wd, c_rd;
    logic [7:0]  c_wen;
    logic [1:0]  c_st;

    assign a_wr_dummy = 1'b0;

    mips_lsu #(.DATA_W(32), .BIG_ENDIAN(1'b1)) u_be32 (
        .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(a_rdy),
        .req_store(req_store), .req_size(req_size), .req_signed(req_signed),
        .req_atomic(req_atomic), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .mem_req_valid(a_mrv), .mem_req_ready(mem_req_ready), .mem_addr(a_maddr),
        .mem_write_en(a_wen), .mem_write_data(a_wd), .mem_rsp_valid(mem_rsp_valid),
        .mem_read_data(mem_rdata[31:0]), .snoop_inv(snoop_inv), .rsp_valid(a_rv),
        .rsp_data(a_rd), .rsp_err(a_re), .busy(a_busy), .dbg_state(a_st)
    );

    mips_lsu #(.DATA_W(32), .BIG_ENDIAN(1'b0)) u_le32 (
        .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(b_rdy),
        .req_store(req_store), .req_size(req_size), .req_signed(req_signed),
        .req_atomic(req_atomic), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .mem_req_valid(b_mrv), .mem_req_ready(mem_req_ready), .mem_addr(b_maddr),
        .mem_write_en(b_wen), .mem_write_data(b_wd), .mem_rsp_valid(mem_rsp_valid),
        .mem_read_data(mem_rdata[31:0]), .snoop_inv(snoop_inv), .rsp_valid(b_rv),
        .rsp_data(b_rd), .rsp_err(b_re), .busy(b_busy), .dbg_state(b_st)
    );

    mips_lsu #(.DATA_W(64), .BIG_ENDIAN(1'b1)) u_be64 (
        .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(c_rdy),
        .req_store(req_store), .req_size(req_size), .req_signed(req_signed),
        .req_atomic(req_atomic), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req_valid(c_mrv), .mem_req_ready(mem_req_ready), .mem_addr(c_maddr),
        .mem_write_en(c_wen), .mem_write_data(c_wd), .mem_rsp_valid(mem_rsp_valid),
        .mem_read_data(mem_rdata), .snoop_inv(snoop_inv), .rsp_valid(c_rv),
        .rsp_data(c_rd), .rsp_err(c_re), .busy(c_busy), .dbg_state(c_st)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Per-instance observations of one operation (0=be32, 1=le32, 2=be64)
    logic        o_mreq  [3];
    logic [31:0] o_addr  [3];
    logic [7:0]  o_wen   [3];
    logic [63:0] o_wdata [3];
    int          o_rcnt  [3];
    int          o_rat   [3];
    logic [63:0] o_rdata [3];
    logic        o_err   [3];

    task automatic capture(input int i, input int c, input logic mrv, input logic [31:0] ma,
                           input logic [7:0] we, input logic [63:0] wd, input logic rv,
                           input logic [63:0] rd, input logic re);
        if (mrv) begin
            o_mreq[i]  = 1'b1;
            o_addr[i]  = ma;
            o_wen[i]   = we;
            o_wdata[i] = wd;
        end
        if (rv) begin
            o_rcnt[i]++;
            o_rat[i]   = c;
            o_rdata[i] = rd;
            o_err[i]   = re;
        end
    endtask

    // ---------------- driver ----------------
    // One operation against zero-wait memory: request presented for one
    // cycle, then OP_CYCLES cycles observed. Cycle c=1 is the cycle after the
    // accepting cycle, so rsp_valid at c=2 is a 3-cycle store and c=3 a
    // 4-cycle load.
    task automatic op(input logic st, input logic [1:0] sz, input logic sg, input logic at,
                      input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            o_mreq[i] = 1'b0; o_addr[i] = '0; o_wen[i] = '0; o_wdata[i] = '0;
            o_rcnt[i] = 0; o_rat[i] = 0; o_rdata[i] = '0; o_err[i] = 1'b0;
        end
        req_valid  = 1'b1;
        req_store  = st;
        req_size   = sz;
        req_signed = sg;
        req_atomic = at;
        req_addr   = addr;
        req_wdata  = wd;
        mem_rdata  = rd;
        for (int c = 1; c <= OP_CYCLES; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            capture(0, c, a_mrv, a_maddr, {4'h0, a_wen}, {32'h0, a_wd}, a_rv, {32'h0, a_rd}, a_re);
            capture(1, c, b_mrv, b_maddr, {4'h0, b_wen}, {32'h0, b_wd}, b_rv, {32'h0, b_rd}, b_re);
            capture(2, c, c_mrv, c_maddr, c_wen, c_wd, c_rv, c_rd, c_re);
        end
    endtask

    // ---------------- directed vectors (32-bit big-endian) ----------------
    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        mreq;
        logic [31:0] maddr;
        logic [3:0]  wen;
        logic [31:0] mwd;
        logic        err;
        logic        chk_d;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int lat;

        vecs[0]  = '{1'b1, 2'd0, 1'b0, 32'h101, 32'hAB, 32'h0, 1'b1, 32'h100, 4'b0100, 32'hABABABAB, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h1234F00D, 1'b1, 32'h100, 4'b0000, 32'h0, 1'b0, 1'b1, 32'hFFFFF00D};
        vecs[2]  = '{1'b0, 2'd1, 1'b0, 32'h100, 32'h0, 32'h1234F00D, 1'b1, 32'h100, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h00001234};
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h123456F0, 1'b1, 32'h100, 4'b0000, 32'h0, 1'b0, 1'b1, 32'hFFFFFFF0};
        vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 32'h8A000000, 1'b1, 32'h100, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h0000008A};
        vecs[5]  = '{1'b1, 2'd1, 1'b0, 32'h106, 32'h0000BEEF, 32'h0, 1'b1, 32'h104, 4'b0011, 32'hBEEFBEEF, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 32'h0, 1'b1, 32'h010, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h203, 32'h0, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 2'd3, 1'b0, 32'h008, 32'h0, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 2'd2, 1'b1, 32'h020, 32'h0, 32'h89ABCDEF, 1'b1, 32'h020, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h89ABCDEF};
        vecs[11] = '{1'b1, 2'd1, 1'b0, 32'h103, 32'h1234, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 2'd0, 1'b1, 32'h101, 32'h0, 32'h00800000, 1'b1, 32'h100, 4'b0000, 32'h0, 1'b0, 1'b1, 32'hFFFFFF80};

        // ---- reset ----
        rst = 1'b1; en = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_atomic = 1'b0; req_addr = '0; req_wdata = '0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = '0; snoop_inv = 1'b0;
        repeat (3) @(negedge clk);
        check("rst state", a_st, S_IDLE);
        check("rst req_ready", a_rdy, 1'b1);
        check("rst mem_req_valid", a_mrv, 1'b0);
        check("rst mem_write_en", a_wen, 4'h0);
        check("rst rsp_valid", a_rv, 1'b0);
        check("rst rsp_err", a_re, 1'b0);
        check("rst rsp_data", a_rd, 32'h0);
        check("rst mem_addr", a_maddr, 32'h0);
        check("rst mem_write_data", a_wd, 32'h0);
        check("rst busy", a_busy, 1'b0);
        rst = 1'b0;

        // ---- table ----
        for (int i = 0; i < 13; i++) begin
            op(vecs[i].st, vecs[i].sz, vecs[i].sg, 1'b0, vecs[i].addr,
               {32'h0, vecs[i].wd}, {32'h0, vecs[i].rd});
            lat = vecs[i].err ? 1 : (vecs[i].st ? 2 : 3);
            check($sformatf("v%0d mreq", i), o_mreq[0], vecs[i].mreq);
            if (vecs[i].mreq) begin
                check($sformatf("v%0d mem_addr", i), o_addr[0], vecs[i].maddr);
                check($sformatf("v%0d mem_write_en", i), o_wen[0], vecs[i].wen);
                if (vecs[i].st) check($sformatf("v%0d mem_write_data", i), o_wdata[0], vecs[i].mwd);
            end
            check($sformatf("v%0d rsp count", i), o_rcnt[0], 1);
            check($sformatf("v%0d rsp cycle", i), o_rat[0], lat);
            check($sformatf("v%0d rsp_err", i), o_err[0], vecs[i].err);
            if (vecs[i].chk_d) check($sformatf("v%0d rsp_data", i), o_rdata[0], vecs[i].data);
            check($sformatf("v%0d busy after", i), a_busy, 1'b0);
        end

        // ---- little-endian ----
        op(1'b0, 2'd1, 1'b1, 1'b0, 32'h102, 64'h0, 64'h1234F00D);
        check("le lh rsp_data", o_rdata[1], 64'h00001234);
        op(1'b1, 2'd0, 1'b0, 1'b0, 32'h101, 64'hAB, 64'h0);
        check("le sb mem_write_en", o_wen[1], 8'h02);
        check("le sb mem_write_data", o_wdata[1], 64'hABABABAB);

        // ---- LL/SC success, then SC again with reservation consumed ----
        op(1'b0, 2'd2, 1'b0, 1'b1, 32'h200, 64'h0, 64'h11111111);
        op(1'b1, 2'd2, 1'b0, 1'b1, 32'h200, 64'h5A5A5A5A, 64'h0);
        check("sc ok mreq", o_mreq[0], 1'b1);
        check("sc ok mem_write_en", o_wen[0], 8'h0F);
        check("sc ok mem_write_data", o_wdata[0], 64'h5A5A5A5A);
        check("sc ok rsp_data", o_rdata[0], 64'h1);
        op(1'b1, 2'd2, 1'b0, 1'b1, 32'h200, 64'h5A5A5A5A, 64'h0);
        check("sc again mreq", o_mreq[0], 1'b0);
        check("sc again rsp_data", o_rdata[0], 64'h0);
        check("sc again rsp count", o_rcnt[0], 1);

        // ---- SC to a different word fails ----
        op(1'b0, 2'd2, 1'b0, 1'b1, 32'h200, 64'h0, 64'h0);
        op(1'b1, 2'd2, 1'b0, 1'b1, 32'h204, 64'h77, 64'h0);
        check("sc addr miss mreq", o_mreq[0], 1'b0);
        check("sc addr miss rsp_data", o_rdata[0], 64'h0);

        // ---- snoop between LL and SC ----
        op(1'b0, 2'd2, 1'b0, 1'b1, 32'h200, 64'h0, 64'h0);
        @(negedge clk); snoop_inv = 1'b1;
        @(negedge clk); snoop_inv = 1'b0;
        op(1'b1, 2'd2, 1'b0, 1'b1, 32'h200, 64'h99, 64'h0);
        check("sc snoop mreq", o_mreq[0], 1'b0);
        check("sc snoop rsp_data", o_rdata[0], 64'h0);
        check("sc snoop rsp count", o_rcnt[0], 1);

        // ---- snoop coincident with LL completion: clear wins ----
        snoop_inv = 1'b1;
        op(1'b0, 2'd2, 1'b0, 1'b1, 32'h200, 64'h0, 64'h0);
        snoop_inv = 1'b0;
        op(1'b1, 2'd2, 1'b0, 1'b1, 32'h200, 64'h99, 64'h0);
        check("sc ll+snoop mreq", o_mreq[0], 1'b0);
        check("sc ll+snoop rsp_data", o_rdata[0], 64'h0);

        // ---- 64-bit instance ----
        op(1'b0, 2'd3, 1'b0, 1'b0, 32'h8, 64'h0, 64'h0123456789ABCDEF);
        check("d64 ld mreq", o_mreq[2], 1'b1);
        check("d64 ld mem_write_en", o_wen[2], 8'h00);
        check("d64 ld mem_addr", o_addr[2], 32'h8);
        check("d64 ld rsp_data", o_rdata[2], 64'h0123456789ABCDEF);
        check("d64 ld rsp_err", o_err[2], 1'b0);
        op(1'b1, 2'd2, 1'b0, 1'b0, 32'h4, 64'hCAFEF00D, 64'h0);
        check("d64 sw mem_write_en", o_wen[2], 8'h0F);
        check("d64 sw mem_write_data", o_wdata[2], 64'hCAFEF00DCAFEF00D);
        check("d64 sw mem_addr", o_addr[2], 32'h0);
        op(1'b0, 2'd2, 1'b1, 1'b0, 32'h0, 64'h0, 64'h80000001_00000000);
        check("d64 lw signed", o_rdata[2], 64'hFFFFFFFF80000001);
        op(1'b0, 2'd2, 1'b0, 1'b0, 32'h4, 64'h0, 64'h00000000_F0000000);
        check("d64 lw unsigned", o_rdata[2], 64'h00000000F0000000);

        // ---- en low holds DONE and rsp_valid ----
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'd0; req_atomic = 1'b0;
        req_addr = 32'h0; req_wdata = 64'h33;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        check("en done rsp_valid", a_rv, 1'b1);
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("en hold state", a_st, S_DONE);
        check("en hold rsp_valid", a_rv, 1'b1);
        en = 1'b1;
        @(negedge clk);
        check("en resume state", a_st, S_IDLE);
        check("en resume rsp_valid", a_rv, 1'b0);

        // ---- memory stall, then reset mid-WAIT ----
        @(negedge clk);
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h40; mem_rdata = 64'hFACEFACE;
        @(negedge clk); req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d mem_req_valid", k), a_mrv, 1'b1);
            check($sformatf("stall%0d mem_addr", k), a_maddr, 32'h40);
            check($sformatf("stall%0d busy", k), a_busy, 1'b1);
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        check("wait state", a_st, S_WAIT);
        check("wait mem_req_valid", a_mrv, 1'b0);
        check("wait busy", a_busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst state", a_st, S_IDLE);
        check("midrst rsp_valid", a_rv, 1'b0);
        check("midrst rsp_data", a_rd, 32'h0);
        check("midrst mem_addr", a_maddr, 32'h0);
        mem_rsp_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("late rsp%0d rsp_valid", k), a_rv, 1'b0);
            check($sformatf("late rsp%0d state", k), a_st, S_IDLE);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
